// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and defaults for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int          DEFAULT_WIDTH    = 32;
    localparam int          DEFAULT_STEP     = 1;
    localparam int unsigned DEFAULT_RESET_PC = 32'd0;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch control, instruction-memory and IF/ID signals
interface pc_sequencer_if
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             halt;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] pc;
    logic             if_valid;
    logic [WIDTH-1:0] if_pc;
    logic             halted;

    modport master (
        input  stall, branch_taken, branch_target, halt, imem_ack,
        output imem_req, imem_addr, pc, if_valid, if_pc, halted
    );

    modport slave (
        output stall, branch_taken, branch_target, halt, imem_ack,
        input  imem_req, imem_addr, pc, if_valid, if_pc, halted
    );
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC mux: branch target > pending redirect > increment > hold
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic             active,
    input  logic             req,
    input  logic             accept,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             redir_pend,
    input  logic [WIDTH-1:0] redir_addr,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (active) begin
            // A branch while a request is in flight must not move the address;
            // it is parked in redir_addr and applied at the accept instead.
            if (branch_taken && (accept || !req)) begin
                pc_next = branch_target;
            end else if (accept && redir_pend) begin
                pc_next = redir_addr;
            end else if (accept) begin
                pc_next = pc + WIDTH'(STEP);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC owner and instruction-memory request sequencer
module pc_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter int               STEP     = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    pc_sequencer_if.master   bus
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] redir_addr;
    logic [WIDTH-1:0] if_pc_q;
    logic             redir_pend;
    logic             outstanding;
    logic             if_valid_q;
    logic             fetching;
    logic             req;
    logic             accept;
    logic             squash;

    assign fetching = (state == FETCH);
    // Stall only blocks a new request; an issued one is held until its ack.
    assign req      = fetching && (outstanding || !bus.stall);
    assign accept   = req && bus.imem_ack;
    assign squash   = bus.branch_taken || redir_pend;

    pc_next_sel #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_pc_next_sel (
        .active        (fetching),
        .req           (req),
        .accept        (accept),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .redir_pend    (redir_pend),
        .redir_addr    (redir_addr),
        .pc            (pc_q),
        .pc_next       (pc_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (bus.halt && (accept || !req)) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            outstanding <= 1'b0;
            redir_pend  <= 1'b0;
            redir_addr  <= '0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
        end else begin
            state       <= state_nxt;
            pc_q        <= pc_nxt;
            outstanding <= req && !bus.imem_ack;
            if_valid_q  <= accept && !squash;
            if (accept && !squash) begin
                if_pc_q <= pc_q;
            end
            if (accept) begin
                redir_pend <= 1'b0;
            end else if (req && bus.branch_taken) begin
                redir_pend <= 1'b1;
                redir_addr <= bus.branch_target;
            end
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.halted    = (state == HALTED);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage controller that owns the program counter and sequences instruction-memory requests.
- Each cycle it chooses the next PC from three sources: the incremented PC, a taken-branch target, or a hold when the pipeline stalls.
- Sits between the hazard/branch logic (EX stage) and the instruction memory. Feeds the IF/ID latch with a valid-qualified PC.

Parameters:
- WIDTH, 32, PC and address width in bits.
- STEP, 1, PC increment per fetched instruction (word-addressed memory).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit holds fetch; no new request while high.
- branch_taken  input  1  single-cycle pulse; redirect PC to branch_target.
- branch_target  input  WIDTH  redirect address, valid when branch_taken=1.
- halt  input  1  stop fetching after the current request completes.
- imem_req  output  1  request to instruction memory.
- imem_addr  output  WIDTH  fetch address; equals pc.
- imem_ack  input  1  memory completes the request this cycle; meaningful only while imem_req=1.
- pc  output  WIDTH  current fetch PC.
- if_valid  output  1  registered one-cycle pulse: one non-squashed fetch delivered.
- if_pc  output  WIDTH  PC of the delivered fetch, valid with if_valid.
- halted  output  1  high in HALTED state.

Behaviour:
- Reset (async, immediate): state=BOOT, pc=RESET_PC, if_valid=0, if_pc=0, imem_req=0, halted=0, redir_pend=0, redir_addr=0.
- States:
  - BOOT: one cycle after rst deasserts, then goes to FETCH unconditionally. Inputs are ignored here.
  - FETCH: imem_req = !stall. imem_addr=pc, held stable while imem_req=1 and no ack has arrived.
  - HALTED: imem_req=0, halted=1. Leaves only on rst.
- Accept event: FETCH && imem_req && imem_ack.
- On accept:
  - If branch_taken or redir_pend is set, the fetch is squashed: if_valid=0 next cycle, pc <= branch_taken ? branch_target : redir_addr, redir_pend <= 0.
  - Otherwise: if_valid=1 and if_pc=pc next cycle, pc <= pc+STEP.
  - If halt=1 at accept: the fetch completes as above (valid or squashed), then next state is HALTED.
- branch_taken with imem_req=1 and no ack (request in flight): redir_pend <= 1, redir_addr <= branch_target. pc is unchanged so the address stays stable.
- branch_taken with imem_req=0 (stall=1): pc <= branch_target immediately. Branch has priority over stall.
- A second branch_taken while redir_pend=1 overwrites redir_addr; the newest target wins.
- stall only gates new requests. It does not cancel a request already issued: once imem_req is high it stays high until ack, even if stall rises mid-request.
  - Implement with an internal outstanding flag: imem_req = FETCH && (outstanding || !stall).
- halt without accept: fetching continues until the next accept, then HALTED. If halt=1 and stall=1 with nothing outstanding, go to HALTED directly.
- Arithmetic: pc+STEP is modulo 2^WIDTH; wrap from all-ones to 0 (for STEP=1) is legal and silent.
- Latency:
  - First request appears in the cycle after BOOT.
  - Each accept gives if_valid the following cycle.
  - With ack tied high and no stall, one fetch per cycle.
- rst asserted mid-request: the request drops immediately, and any pending redirect and if_valid are cleared.

Decomposition:
- Shared package (fetch_pkg): state encoding constants BOOT/FETCH/HALTED (2-bit), default RESET_PC, STEP.
- One natural sub-module, pc_next_sel: combinational next-PC mux (increment / branch_target / redir_addr / hold), with priority branch_taken > redir_pend > increment.
- The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then free-run, imem_ack=1, stall=0 → imem_addr sequence 0,1,2,3; if_valid pulses each cycle with if_pc 0,1,2 (one cycle behind).
- Stall=1 for 3 cycles at pc=5 → imem_req=0, pc holds 5, no if_valid; fetch resumes at 5 after release.
- Ack delayed 2 cycles on pc=8, branch_taken with target 0x40 in the wait cycle → imem_addr stays 8 until ack; that fetch is squashed (if_valid=0); next request at 0x40.
- Branch to 0x100 while stall=1 → pc=0x100 next cycle; first request after release is at 0x100.
- pc=0xFFFFFFFF, ack → pc wraps to 0; if_pc=0xFFFFFFFF with if_valid=1.
- halt raised with ack at pc=3 → if_valid for 3, then halted=1, imem_req=0 for good. Asserting rst mid-request clears every output to its reset value.
